// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  typedef struct packed {
    logic [AW-1:0] reg_a;
    logic [DW-1:0] data;
  } wb_entry_t;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding pending long-latency writebacks.
// Push while full and pop while empty are ignored.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  wb_entry_t wdata_i,
  input  logic      pop_i,
  output wb_entry_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0]   CntOne = 1;
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   cnt_q;
  logic            push_en, pop_en;

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + PtrOne;
      if (pop_en)  rptr_q <= rptr_q + PtrOne;
      if (push_en && !pop_en) begin
        cnt_q <= cnt_q + CntOne;
      end else if (pop_en && !push_en) begin
        cnt_q <= cnt_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU path (priority) merged with a FIFO-buffered
// long-latency path, plus a busy scoreboard. WB_BYPASS_EN lets B skip an empty FIFO.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          a_valid,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_reg,
  input  logic [AW-1:0] RegRead_1,
  input  logic [AW-1:0] RegRead_2,
  output logic          busy_1,
  output logic          busy_2,
  output logic          RegWrite,
  output logic [AW-1:0] w_reg,
  output logic [DW-1:0] w_data
);

  import regfile_pkg::*;

  wb_entry_t       head, sel_entry;
  logic            full, empty, push, pop, bypass, sel_valid;
  logic            clr_valid;
  logic [AW-1:0]   clr_reg;
  logic [NREG-1:0] busy_q, busy_d;
  logic            reg_write_q;
  logic [AW-1:0]   w_reg_q;
  logic [DW-1:0]   w_data_q;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .push_i  (push),
    .wdata_i ('{reg_a: b_reg, data: b_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign b_ready = !full;

  always_comb begin
    bypass = 1'b0;
`ifdef WB_BYPASS_EN
    bypass = !a_valid && empty && b_valid;
`endif
    push      = b_valid && !full && !bypass;
    pop       = !a_valid && !empty;
    sel_valid = 1'b0;
    sel_entry = head;
    clr_valid = pop || bypass;
    clr_reg   = pop ? head.reg_a : b_reg;
    if (a_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{reg_a: a_reg, data: a_data};
    end else if (pop) begin
      sel_valid = 1'b1;
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_entry = '{reg_a: b_reg, data: b_data};
    end
  end

  // Clear before set so a same-cycle issue of the popped register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_reg] = 1'b0;
    if (issue_valid && (issue_reg != REG_ZERO)) busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q      <= '0;
      reg_write_q <= 1'b0;
      w_reg_q     <= '0;
      w_data_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      reg_write_q <= sel_valid && (sel_entry.reg_a != REG_ZERO);
      if (sel_valid) begin
        w_reg_q  <= sel_entry.reg_a;
        w_data_q <= sel_entry.data;
      end
    end
  end

  assign busy_1   = busy_q[RegRead_1];
  assign busy_2   = busy_q[RegRead_2];
  assign RegWrite = reg_write_q;
  assign w_reg    = w_reg_q;
  assign w_data   = w_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_reg = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_reg = '0;
  logic [31:0] b_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic [4:0]  RegRead_1 = '0;
  logic [4:0]  RegRead_2 = '0;
  logic        busy_1, busy_2, RegWrite;
  logic [4:0]  w_reg;
  logic [31:0] w_data;

  regfile_wb_arbiter #(
    .DEPTH (DEPTH),
    .AW    (5),
    .DW    (32)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .a_valid     (a_valid),
    .a_reg       (a_reg),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_reg       (b_reg),
    .b_data      (b_data),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .RegRead_1   (RegRead_1),
    .RegRead_2   (RegRead_2),
    .busy_1      (busy_1),
    .busy_2      (busy_2),
    .RegWrite    (RegWrite),
    .w_reg       (w_reg),
    .w_data      (w_data)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending B writes as a queue, busy flags as a bit array.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          mbusy[32];
  logic        m_we = 1'b0;
  logic [4:0]  m_wreg = '0;
  logic [31:0] m_wdata = '0;

  task automatic model_step();
    bit          sel;
    bit          byp;
    logic [4:0]  sr;
    logic [31:0] sd;
    int          occ;
    ent_t        e;
    sel = 0;
    byp = 0;
    sr  = '0;
    sd  = '0;
    occ = mq.size();
    if (!RESET_N) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 0;
      m_we    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
    end else begin
      if (a_valid) begin
        sel = 1;
        sr  = a_reg;
        sd  = a_data;
      end else if (occ > 0) begin
        e = mq.pop_front();
        sel = 1;
        sr  = e.r;
        sd  = e.d;
        mbusy[e.r] = 0;
      end
`ifdef WB_BYPASS_EN
      else if (b_valid) begin
        byp = 1;
        sel = 1;
        sr  = b_reg;
        sd  = b_data;
        mbusy[b_reg] = 0;
      end
`endif
      if (b_valid && occ < DEPTH && !byp) mq.push_back('{b_reg, b_data});
      if (issue_valid && issue_reg != 0) mbusy[issue_reg] = 1;
      mbusy[0] = 0;
      m_we = sel && (sr != 0);
      if (sel) begin
        m_wreg  = sr;
        m_wdata = sd;
      end
    end
  endtask

  always @(posedge CLK or negedge RESET_N) model_step();

  always @(negedge CLK) begin
    check("RegWrite", {31'b0, RegWrite}, {31'b0, m_we});
    check("w_reg", {27'b0, w_reg}, {27'b0, m_wreg});
    check("w_data", w_data, m_wdata);
    check("b_ready", {31'b0, b_ready}, {31'b0, mq.size() < DEPTH});
    check("busy_1", {31'b0, busy_1}, {31'b0, mbusy[RegRead_1]});
    check("busy_2", {31'b0, busy_2}, {31'b0, mbusy[RegRead_2]});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    #1 RESET_N = 1'b0;
    tick();
    tick();
    check("rst_regwrite", {31'b0, RegWrite}, 32'd0);
    check("rst_b_ready", {31'b0, b_ready}, 32'd1);
    RESET_N = 1'b1;
    tick();

    // A-only write
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hDEADBEEF;
    tick();
    check("a_we", {31'b0, RegWrite}, 32'd1);
    check("a_reg", {27'b0, w_reg}, 32'd3);
    check("a_data", w_data, 32'hDEADBEEF);
    idle();
    tick();
    check("idle_we", {31'b0, RegWrite}, 32'd0);
    check("idle_hold", w_data, 32'hDEADBEEF);

    // A priority over a queued B
    a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h1;
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h11;
    tick();
    b_valid = 1'b0; a_reg = 5'd5; a_data = 32'h2;
    tick();
    a_reg = 5'd6; a_data = 32'h3;
    tick();
    check("prio_a", {27'b0, w_reg}, 32'd6);
    idle();
    tick();
    check("prio_b_we", {31'b0, RegWrite}, 32'd1);
    check("prio_b_reg", {27'b0, w_reg}, 32'd7);
    check("prio_b_data", w_data, 32'h11);
    tick();

    // Fill the FIFO under continuous A traffic
    a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hA;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_reg = 5'(10 + i); b_data = 32'h100 + i;
      tick();
    end
    check("full_ready", {31'b0, b_ready}, 32'd0);
    b_reg = 5'd14; b_data = 32'h104;
    tick();
    check("full_drop_ready", {31'b0, b_ready}, 32'd0);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_we", {31'b0, RegWrite}, 32'd1);
      check("drain_reg", {27'b0, w_reg}, 32'(10 + i));
      check("drain_data", w_data, 32'h100 + i);
    end
    tick();
    check("drain_empty_we", {31'b0, RegWrite}, 32'd0);

    // Register 0 on both paths
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h55;
    tick();
    check("a_r0_we", {31'b0, RegWrite}, 32'd0);
    a_valid = 1'b0;
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'h66;
    tick();
    b_valid = 1'b0;
    tick();
    check("b_r0_we", {31'b0, RegWrite}, 32'd0);
    tick();
    check("b_r0_consumed", {31'b0, RegWrite}, 32'd0);

    // Scoreboard set/clear races
    RegRead_1 = 5'd9; RegRead_2 = 5'd9;
    issue_valid = 1'b1; issue_reg = 5'd9;
    tick();
    issue_valid = 1'b0;
    check("sb_set", {31'b0, busy_1}, 32'd1);
    a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h22;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h90;
    tick();
    b_data = 32'h91;
    tick();
    idle();
    issue_valid = 1'b1; issue_reg = 5'd9;
    tick();
    issue_valid = 1'b0;
    check("sb_set_wins", {31'b0, busy_1}, 32'd1);
    check("sb_pop1_data", w_data, 32'h90);
    tick();
    check("sb_clear", {31'b0, busy_2}, 32'd0);
    check("sb_pop2_data", w_data, 32'h91);

    // Reset in the middle of traffic
    RegRead_1 = 5'd5;
    a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h33;
    issue_valid = 1'b1; issue_reg = 5'd5;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_reg = 5'(20 + i); b_data = 32'h200 + i;
      tick();
      issue_valid = 1'b0;
    end
    idle();
    check("mid_busy", {31'b0, busy_1}, 32'd1);
    RESET_N = 1'b0;
    #2;
    check("mid_rst_we", {31'b0, RegWrite}, 32'd0);
    check("mid_rst_ready", {31'b0, b_ready}, 32'd1);
    check("mid_rst_busy", {31'b0, busy_1}, 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();
    check("mid_rst_empty", {31'b0, RegWrite}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
